// File: rtl/chip8_pkg.sv
// chip8_pkg: shared memory map constants and loader state encoding
package chip8_pkg;
  localparam int MEMORY_SIZE = 4096;
  localparam int ADDR_W = 12;
  localparam int FONT_BYTES = 80;
  localparam logic [ADDR_W-1:0] PROG_BASE = 12'h200;
  localparam logic [ADDR_W-1:0] FONT_BASE = 12'h050;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEMORY_SIZE - 1);
  typedef enum logic [2:0] {IDLE, FONT, PROG, ERR, DONE} loader_state_e;
endpackage

// File: rtl/chip8_font_rom.sv
// chip8_font_rom: combinational hex glyph table, 5 bytes per digit 0-F
module chip8_font_rom
  import chip8_pkg::*;
(
  input  logic [6:0] idx,
  output logic [7:0] data
);
  localparam logic [7:0] GLYPHS [FONT_BYTES] = '{
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,
    8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,
    8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,
    8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,
    8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,
    8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,
    8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
  };
  assign data = idx < 7'(FONT_BYTES) ? GLYPHS[idx] : 8'h00;
endmodule

// File: rtl/chip8_rom_loader.sv
// chip8_rom_loader: font + program image loader into CHIP-8 memory; font stage enabled by CHIP8_LOADER_FONT_EN
module chip8_rom_loader
  import chip8_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_write_addr,
  output logic [7:0]        mem_write_data,
  output logic              busy,
  output logic              done,
  output logic              overflow_err,
  output logic [ADDR_W-1:0] byte_count
);
  loader_state_e state;
  logic [ADDR_W-1:0] addr;
  logic hs;
  assign in_ready = state == PROG || state == ERR;
  assign busy = state == FONT || in_ready;
  assign done = state == DONE;
  assign hs = in_valid && in_ready;
`ifdef CHIP8_LOADER_FONT_EN
  localparam loader_state_e LOAD = FONT;
  logic [6:0] idx;
  logic [7:0] font_byte;
  chip8_font_rom u_font (.idx(idx), .data(font_byte));
  // font index walks 0..79 while in FONT
  always_ff @(posedge clk)
    if (!rst_n || state != FONT) idx <= '0;
    else idx <= idx + 7'd1;
`else
  localparam loader_state_e LOAD = PROG;
`endif
  // state sequencing and registered memory write port
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      addr <= '0;
      mem_write <= 1'b0;
      mem_write_addr <= '0;
      mem_write_data <= '0;
      overflow_err <= 1'b0;
      byte_count <= '0;
    end else begin
      mem_write <= 1'b0;
      if ((state == IDLE || state == DONE) && start) begin
        state <= LOAD;
        addr <= PROG_BASE;
        overflow_err <= 1'b0;
        byte_count <= '0;
      end
`ifdef CHIP8_LOADER_FONT_EN
      else if (state == FONT) begin
        mem_write <= 1'b1;
        mem_write_addr <= FONT_BASE + ADDR_W'(idx);
        mem_write_data <= font_byte;
        if (idx == 7'(FONT_BYTES - 1)) state <= PROG;
      end
`endif
      else if (state == PROG && hs) begin
        mem_write <= 1'b1;
        mem_write_addr <= addr;
        mem_write_data <= in_data;
        byte_count <= byte_count + 12'd1;
        addr <= addr == LAST_ADDR ? addr : addr + 12'd1;
        if (in_last) state <= DONE;
        else if (addr == LAST_ADDR) begin
          state <= ERR;
          overflow_err <= 1'b1;
        end
      end else if (state == ERR && hs && in_last) state <= DONE;
    end
endmodule

// File: tb/tb_chip8_rom_loader.sv
// tb_chip8_rom_loader: scoreboard bench for chip8_rom_loader
module tb_chip8_rom_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic in_last = 1'b0;
  logic in_ready, mem_write, busy, done, overflow_err;
  logic [11:0] mem_write_addr, byte_count;
  logic [7:0] mem_write_data;
  int checks = 0;
  int failures = 0;
  int exp_addr = 0;
  logic [19:0] sb [$];
  localparam logic [7:0] FT [80] = '{
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0, 8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0, 8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10, 8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0, 8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0, 8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90, 8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0, 8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0, 8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
  };

  chip8_rom_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .mem_write(mem_write),
    .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data), .busy(busy),
    .done(done), .overflow_err(overflow_err), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk)
    if (mem_write) begin
      if (sb.size() == 0) check("unexpected_write", {8'h0, mem_write_addr, mem_write_data}, 32'hFFFFFFFF);
      else begin
        logic [19:0] e;
        e = sb.pop_front();
        check("write", {12'h0, mem_write_addr, mem_write_data}, {12'h0, e});
      end
    end

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    exp_addr = 'h200;
`ifdef CHIP8_LOADER_FONT_EN
    for (int i = 0; i < 80; i++) sb.push_back({12'(12'h050 + i), FT[i]});
`endif
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic l, input int gap);
    int t = 0;
    in_valid = 1'b1;
    in_data = d;
    in_last = l;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("ready_timeout", 0, 1);
    else begin
      if (exp_addr <= 'hFFF) sb.push_back({12'(exp_addr), d});
      exp_addr++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    repeat (3) @(negedge clk);
    check(tag, sb.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_mem_write"}, mem_write, 0);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_ovf"}, overflow_err, 0);
    check({tag, "_count"}, byte_count, 0);
  endtask

  task automatic check_end(input string tag, input int cnt, input logic ovf);
    check({tag, "_done"}, done, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ovf"}, overflow_err, ovf);
    check({tag, "_count"}, byte_count, cnt);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] prog [4] = '{8'h00, 8'hE0, 8'h12, 8'h00};
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    do_start();
    check("busy_after_start", busy, 1);
`ifdef CHIP8_LOADER_FONT_EN
    check("font_ready_low", in_ready, 0);
    repeat (40) @(negedge clk);
    check("font_ready_mid", in_ready, 0);
`else
    check("ready_after_start", in_ready, 1);
`endif
    for (int i = 0; i < 4; i++) send(prog[i], i == 3, 0);
    drain("short_drain");
    check_end("short", 4, 0);
    in_valid = 1'b1;
    in_data = 8'hAA;
    repeat (3) @(negedge clk);
    check("done_ready_low", in_ready, 0);
    in_valid = 1'b0;
    do_start();
    check("restart_cleared_done", done, 0);
    check("restart_cleared_count", byte_count, 0);
    for (int i = 0; i < 6; i++) begin
      send(8'(8'h30 + i), i == 5, i % 2 == 0 ? 1 : 0);
      if (i == 2) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_while_busy", byte_count, 3);
      end
    end
    drain("gap_drain");
    check_end("gap", 6, 0);
    do_start();
    for (int i = 0; i < 3584; i++) send(8'(i * 7 + 1), i == 3583, 0);
    drain("fit_drain");
    check_end("fit", 3584, 0);
    do_start();
    for (int i = 0; i < 3584; i++) send(8'(i ^ 8'h5A), 1'b0, 0);
    check("ovf_err_state_ovf", overflow_err, 1);
    check("ovf_err_state_busy", busy, 1);
    check("ovf_err_state_ready", in_ready, 1);
    send(8'h11, 1'b0, 0);
    send(8'h22, 1'b1, 0);
    drain("ovf_drain");
    check_end("ovf", 3584, 1);
    do_start();
    for (int i = 0; i < 10; i++) send(8'(8'hC0 + i), 1'b0, 0);
    check("mid_count", byte_count, 10);
    in_valid = 1'b1;
    in_data = 8'hEE;
    rst_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_ready", in_ready, 0);
    in_valid = 1'b0;
    do_start();
    for (int i = 0; i < 4; i++) send(prog[i], i == 3, 0);
    drain("reload_drain");
    check_end("reload", 4, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/chip8_rom_loader.md
Name: chip8_rom_loader

Overview:
- Upstream feeder of the CHIP-8 4096x8 main memory. Drives the memory write port only.
- On start, writes the 80-byte hex font at FONT_BASE, then streams a program image from a byte source (UART/SPI front-end) into memory from PROG_BASE upward.
- Reports done, byte count and overflow. The CPU is held off until done.

Parameters:
- MEMORY_SIZE, 4096, bytes in main memory; the last writable address is MEMORY_SIZE-1.
- PROG_BASE, 12'h200, first program address.
- FONT_BASE, 12'h050, first font address.

Ports:
- clk  in  1  system clock, all logic on its rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  single-cycle pulse that begins a load; ignored while busy.
- in_valid  in  1  source byte valid.
- in_data  in  8  source byte.
- in_last  in  1  marks the final byte of the image; qualified by in_valid.
- in_ready  out  1  loader accepts the byte; transfer occurs when in_valid && in_ready.
- mem_write  out  1  write strobe to memory.
- mem_write_addr  out  12  write address.
- mem_write_data  out  8  write data.
- busy  out  1  high in FONT, PROG and ERR.
- done  out  1  level; high in DONE.
- overflow_err  out  1  sticky; set when the image exceeds memory.
- byte_count  out  12  program bytes written this load.

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; all outputs 0; internal address 0. Reset mid-load aborts immediately, with no further writes.
- States:
  - IDLE --start--> FONT.
  - FONT: one font byte per cycle at FONT_BASE+i, i=0..79. After i=79 the state becomes PROG and the address is loaded with PROG_BASE.
  - PROG: in_ready=1. Each handshake produces a write at addr, then addr+1 and byte_count+1.
    - Handshake with in_last=1 -> DONE.
    - Handshake at addr==MEMORY_SIZE-1 with in_last=0 -> ERR. That byte is written; overflow_err=1 next cycle.
  - ERR: in_ready=1. Bytes are discarded with no mem_write; byte_count frozen. A handshake with in_last=1 -> DONE, with overflow_err still 1.
  - DONE: done=1, in_ready=0. start -> FONT and clears done, overflow_err and byte_count.
- Write timing: mem_write, mem_write_addr and mem_write_data are registered. The write appears exactly 1 cycle after the handshake or font step; mem_write is a 1-cycle pulse per byte.
- Address arithmetic is 12-bit and never wraps. The overflow check precedes the increment, so 0xFFF -> 0x000 never produces a write.
- in_ready is 0 in IDLE, FONT and DONE. Source bytes offered then are not consumed.
- start while busy is ignored. start and rst_n low together: reset wins.
- Maximum image is MEMORY_SIZE-PROG_BASE = 3584 bytes. An image of exactly 3584 bytes with in_last on the final byte -> DONE, no error.
- Back-to-back valid bytes sustain 1 byte/cycle.

Optional Feature:
- Macro: CHIP8_LOADER_FONT_EN.
- Defined: FONT state present; 80 font bytes written as above; first program write occurs no earlier than 81 cycles after start.
- Undefined: FONT state removed; start goes directly to PROG with addr=PROG_BASE; in_ready=1 the cycle after start; no writes below PROG_BASE.

Decomposition:
- Package chip8_pkg: MEMORY_SIZE, PROG_BASE, FONT_BASE, FONT_BYTES=80, ADDR_W=12, and the loader state enum (IDLE, FONT, PROG, ERR, DONE).
- Sub-module chip8_font_rom: combinational 7-bit index -> 8-bit font byte, the standard 0-F glyphs at 5 bytes each. Instantiated only under CHIP8_LOADER_FONT_EN.

Test Plan:
- Font load (FONT_EN): start pulse -> 80 writes on consecutive cycles. Writes 0x050=0xF0, 0x051=0x90, 0x09F=0x80. in_ready=0 throughout.
- Short program: after font, send 0x00,0xE0,0x12,0x00 (last on 0x00).
  - Writes: 0x200=0x00, 0x201=0xE0, 0x202=0x12, 0x203=0x00.
  - Result: done=1, byte_count=4, overflow_err=0.
- Backpressure/gaps: in_valid toggling 1,0,1 -> writes only on handshakes, addresses contiguous, no duplicate writes.
- Exact fit: 3584 bytes with last on the final byte -> last write at 0xFFF; done=1, overflow_err=0, byte_count=3584.
- Overflow: 3586 bytes, last on the final byte.
  - Last write at 0xFFF; 2 bytes discarded with no writes.
  - Result: overflow_err=1, done=1, byte_count=3584.
- Reset mid-load: rst_n=0 during PROG after 10 bytes -> next cycle all outputs 0, state IDLE, no further writes. A new start reloads from the font.
